// File: rtl/sevenseg_scan_driver.sv
// ============================================================================
// sevenseg_scan_driver
// ----------------------------------------------------------------------------
// Purpose:
//   Display stage for the Basys3 LED rotator. Takes a 16-bit hex value plus
//   four decimal-point requests and time-multiplexes them onto the 4-digit
//   common-anode seven-segment display.
//
//   - A slot counter divides the clock into digit slots of DIGIT_PERIOD cycles.
//     Four slots make one frame.
//   - The first BLANK_CYCLES cycles of every slot keep all anodes off. This
//     lets the previous digit's cathode pattern drain away so it does not ghost
//     onto the next digit.
//   - New values are staged in a pending register. They move into the display
//     register only at a frame boundary, so a frame never shows a torn value.
//   - Leading-zero suppression and per-digit enables act live.
//
// Ports:
//   clk          system clock (100 MHz on the board)
//   rst          synchronous reset, active-high
//   value_in     hex value, nibble k drives digit k (digit 0 = rightmost)
//   dp_in        decimal-point request per digit, active-high
//   value_valid  single-cycle strobe capturing value_in / dp_in
//   digit_en     per-digit enable, applied live
//   lz_blank     leading-zero suppression enable, applied live
//   an           anode drives, active-low
//   seg          cathodes {g,f,e,d,c,b,a}, active-low
//   dp           decimal-point cathode, active-low
//   frame_start  high for the single cycle in which the display register loads
// ============================================================================
module sevenseg_scan_driver #(
    parameter int DIGIT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        value_valid,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CNT_W = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [6:0]       SEG_OFF   = 7'h7F;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] slot_cnt_q,  slot_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [15:0]      pend_val_q,  pend_val_d;
    logic [3:0]       pend_dp_q,   pend_dp_d;
    logic [15:0]      disp_val_q,  disp_val_d;
    logic [3:0]       disp_dp_q,   disp_dp_d;
    logic [3:0]       an_q,        an_d;
    logic [6:0]       seg_q,       seg_d;
    logic             dp_q,        dp_d;

    // Internal combinational signals
    logic             slot_wrap;
    logic             frame_tick;
    logic             blank_active;
    logic [3:0]       cur_nibble;
    logic [3:0]       lz_supp;
    logic             lit;

    // ------------------------------------------------------------------------
    // Hex to active-low seven-segment decode, bit order {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Scan timing: slot counter and digit index.
    // The frame boundary is the last cycle of digit 3's slot. The display
    // register loads on the edge that ends that cycle, so the new value is in
    // place from the very first cycle of digit 0's slot.
    // ------------------------------------------------------------------------
    always_comb begin
        slot_cnt_d  = slot_cnt_q;
        digit_idx_d = digit_idx_q;
        slot_wrap   = (slot_cnt_q == SLOT_LAST);
        frame_tick  = slot_wrap && (digit_idx_q == 2'd3);
        if (slot_wrap) begin
            slot_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end else begin
            slot_cnt_d  = slot_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Value staging.
    // Strobes always land in the pending register, and the last strobe of a
    // frame wins. A strobe that coincides with the frame boundary also goes
    // straight into the display register. Otherwise a value arriving exactly
    // at the boundary would wait a whole extra frame.
    // ------------------------------------------------------------------------
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (value_valid) begin
            pend_val_d = value_in;
            pend_dp_d  = dp_in;
        end
        if (frame_tick) begin
            if (value_valid) begin
                disp_val_d = value_in;
                disp_dp_d  = dp_in;
            end else begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Lit decision for the digit currently being scanned.
    // A digit above 0 is suppressed when it and every more significant nibble
    // are zero. Digit 0 always shows, so a zero value still reads "0".
    // ------------------------------------------------------------------------
    always_comb begin
        cur_nibble = disp_val_q[3:0];
        case (digit_idx_q)
            2'd0:    cur_nibble = disp_val_q[3:0];
            2'd1:    cur_nibble = disp_val_q[7:4];
            2'd2:    cur_nibble = disp_val_q[11:8];
            default: cur_nibble = disp_val_q[15:12];
        endcase

        lz_supp    = 4'b0000;
        lz_supp[3] = lz_blank && (disp_val_q[15:12] == 4'h0);
        lz_supp[2] = lz_supp[3] && (disp_val_q[11:8] == 4'h0);
        lz_supp[1] = lz_supp[2] && (disp_val_q[7:4] == 4'h0);

        blank_active = (BLANK_CYCLES != 0) && (slot_cnt_q < BLANK_END);

        lit = !blank_active && digit_en[digit_idx_q] && !lz_supp[digit_idx_q];
    end

    // ------------------------------------------------------------------------
    // Next output values. All three outputs are registered together, so the
    // anode and cathode patterns always switch on the same edge.
    // ------------------------------------------------------------------------
    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = ~(4'b0001 << digit_idx_q);
            seg_d = hex_to_seg(cur_nibble);
            dp_d  = ~disp_dp_q[digit_idx_q];
        end
    end

    // ------------------------------------------------------------------------
    // Register bank with synchronous reset. Reset blanks the display on the
    // next edge and restarts the scan from digit 0.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= 2'd0;
            pend_val_q  <= 16'h0000;
            pend_dp_q   <= 4'h0;
            disp_val_q  <= 16'h0000;
            disp_dp_q   <= 4'h0;
            an_q        <= 4'hF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    // frame_start is decoded from registered state. Gating it with rst keeps
    // it low while reset is held.
    assign frame_start = frame_tick && !rst;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// ============================================================================
// tb_sevenseg_scan_driver
// ----------------------------------------------------------------------------
// Directed bench for sevenseg_scan_driver with DIGIT_PERIOD=8 and
// BLANK_CYCLES=2.
//
// pos numbering: pos p is the cycle whose scan state is (slot (p-1)/8,
// count (p-1)%8). pos 0 is the frame_start cycle. Because outputs lag the
// state by one cycle, digit k is blank at pos 8k+2..8k+3 and lit at
// pos 8k+4..8k+9.
// ============================================================================
module tb_sevenseg_scan_driver;

    localparam int DIGIT_PERIOD = 8;
    localparam int BLANK_CYCLES = 2;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        value_valid;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int errors = 0;
    int checks = 0;
    int pos    = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .DIGIT_PERIOD(DIGIT_PERIOD),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .value_valid(value_valid),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    // Advance one cycle, sample on the falling edge, and check the invariants
    // that hold in every cycle: at most one anode low, and dark cathodes
    // whenever all anodes are off.
    task automatic tick();
        @(negedge clk);
        pos++;
        checks++;
        if ($countones(~an) > 1) begin
            errors++;
            $display("[TB] FAIL onehot_an pos=%0d: an=%b, required at most one low bit", pos, an);
        end
        checks++;
        if (an == 4'hF && (seg !== SEG_OFF || dp !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL dark_cathodes pos=%0d: seg=%b dp=%b, required seg=1111111 dp=1", pos, seg, dp);
        end
    endtask

    task automatic goto_pos(input int p);
        while (pos < p) tick();
    endtask

    // Run to the next frame_start with a cycle budget, then set pos to 0.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 100);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_timeout: frame_start=%b after %0d cycles, required 1", frame_start, n);
        end
        pos = 0;
    endtask

    task automatic strobe(input logic [15:0] v, input logic [3:0] d);
        value_in    = v;
        dp_in       = d;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; value_in = '0; dp_in = '0; value_valid = 1'b0;
        digit_en = 4'hF; lz_blank = 1'b0;
        repeat (3) tick();
        checks++;
        if (an !== 4'hF || seg !== SEG_OFF || dp !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: an=%h seg=%b dp=%b fs=%b, required F 1111111 1 0", an, seg, dp, frame_start);
        end
    endtask

    task automatic test_scan_timing();
        int n;
        rst = 1'b0;
        pos = 1;
        checks++;
        if (an !== 4'hF) begin errors++; $display("[TB] FAIL blank_c0: an=%h, required F", an); end
        goto_pos(3);
        checks++;
        if (an !== 4'hF) begin errors++; $display("[TB] FAIL blank_c2: an=%h, required F", an); end
        goto_pos(4);
        checks++;
        if (an !== 4'hE || seg !== SEG_0 || dp !== 1'b1) begin
            errors++; $display("[TB] FAIL lit_c3: an=%h seg=%b dp=%b, required E 1000000 1", an, seg, dp);
        end
        goto_pos(9);
        checks++;
        if (an !== 4'hE || seg !== SEG_0) begin
            errors++; $display("[TB] FAIL lit_c8: an=%h seg=%b, required E 1000000", an, seg);
        end
        goto_pos(10);
        checks++;
        if (an !== 4'hF) begin errors++; $display("[TB] FAIL blank_slot1: an=%h, required F", an); end
        goto_pos(12);
        checks++;
        if (an !== 4'hD || seg !== SEG_0) begin
            errors++; $display("[TB] FAIL lit_slot1: an=%h seg=%b, required D 1000000", an, seg);
        end
        wait_frame(n);
        checks++;
        if (n != 20) begin errors++; $display("[TB] FAIL first_frame: arrived after %0d cycles, required 20", n); end
        wait_frame(n);
        checks++;
        if (n != 32) begin errors++; $display("[TB] FAIL frame_period: %0d cycles, required 32", n); end
    endtask

    task automatic test_capture();
        int n;
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        logic       exp_dp [4];
        goto_pos(10);
        strobe(16'h1A3F, 4'b0100);
        for (int k = 1; k < 4; k++) begin
            goto_pos(8 * k + 6);
            checks++;
            if (an !== ~(4'b0001 << k) || seg !== SEG_0 || dp !== 1'b1) begin
                errors++;
                $display("[TB] FAIL capture_held d%0d: an=%h seg=%b dp=%b, required old value 0", k, an, seg, dp);
            end
        end
        wait_frame(n);
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_seg = '{SEG_F, SEG_3, SEG_A, SEG_1};
        exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            goto_pos(8 * k + 3);
            checks++;
            if (an !== 4'hF) begin errors++; $display("[TB] FAIL capture_blank d%0d: an=%h, required F", k, an); end
            goto_pos(8 * k + 6);
            checks++;
            if (an !== exp_an[k] || seg !== exp_seg[k] || dp !== exp_dp[k]) begin
                errors++;
                $display("[TB] FAIL capture_show d%0d: an=%h seg=%b dp=%b, required %h %b %b",
                         k, an, seg, dp, exp_an[k], exp_seg[k], exp_dp[k]);
            end
        end
    endtask

    task automatic test_lz_blank();
        int n;
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        strobe(16'h0040, 4'b0000);
        lz_blank = 1'b1;
        wait_frame(n);
        exp_an  = '{4'hE, 4'hD, 4'hF, 4'hF};
        exp_seg = '{SEG_0, SEG_4, SEG_OFF, SEG_OFF};
        for (int k = 0; k < 4; k++) begin
            goto_pos(8 * k + 6);
            checks++;
            if (an !== exp_an[k] || seg !== exp_seg[k] || dp !== 1'b1) begin
                errors++;
                $display("[TB] FAIL lz_on d%0d: an=%h seg=%b dp=%b, required %h %b 1", k, an, seg, dp, exp_an[k], exp_seg[k]);
            end
        end
        wait_frame(n);
        lz_blank = 1'b0;
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_seg = '{SEG_0, SEG_4, SEG_0, SEG_0};
        for (int k = 0; k < 4; k++) begin
            goto_pos(8 * k + 6);
            checks++;
            if (an !== exp_an[k] || seg !== exp_seg[k]) begin
                errors++;
                $display("[TB] FAIL lz_off d%0d: an=%h seg=%b, required %h %b", k, an, seg, exp_an[k], exp_seg[k]);
            end
        end
    endtask

    task automatic test_digit_en();
        int n;
        int bad;
        digit_en = 4'b0101;
        wait_frame(n);
        bad = 0;
        while (pos < 31) begin
            tick();
            if (an[1] === 1'b0 || an[3] === 1'b0) bad++;
            if (pos == 6) begin
                checks++;
                if (an !== 4'hE || seg !== SEG_0) begin
                    errors++; $display("[TB] FAIL en_d0: an=%h seg=%b, required E 1000000", an, seg);
                end
            end
            if (pos == 22) begin
                checks++;
                if (an !== 4'hB || seg !== SEG_0) begin
                    errors++; $display("[TB] FAIL en_d2: an=%h seg=%b, required B 1000000", an, seg);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL en_disabled: %0d cycles with an[1]/an[3] low, required 0", bad);
        end
        digit_en = 4'hF;
    endtask

    task automatic test_back_to_back();
        int n;
        int bad;
        wait_frame(n);
        goto_pos(4);
        strobe(16'h1111, 4'b0000);
        goto_pos(14);
        checks++;
        if (an !== 4'hD || seg !== SEG_4) begin
            errors++; $display("[TB] FAIL b2b_hold1: an=%h seg=%b, required D 0011001", an, seg);
        end
        strobe(16'h2222, 4'b0000);
        goto_pos(22);
        checks++;
        if (an !== 4'hB || seg !== SEG_0) begin
            errors++; $display("[TB] FAIL b2b_hold2: an=%h seg=%b, required B 1000000", an, seg);
        end
        wait_frame(n);
        strobe(16'h3333, 4'b0000);
        bad = 0;
        while (pos < 31) begin
            tick();
            if (seg === SEG_1 || seg === SEG_2) bad++;
            if (pos % 8 == 6) begin
                checks++;
                if (an !== ~(4'b0001 << (pos / 8)) || seg !== SEG_3) begin
                    errors++;
                    $display("[TB] FAIL b2b_bypass d%0d: an=%h seg=%b, required %h 0110000",
                             pos / 8, an, seg, ~(4'b0001 << (pos / 8)));
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL b2b_stale: %0d cycles showing 1 or 2, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        wait_frame(n);
        goto_pos(22);
        checks++;
        if (an !== 4'hB || seg !== SEG_3) begin
            errors++; $display("[TB] FAIL rst_pre: an=%h seg=%b, required B 0110000", an, seg);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (an !== 4'hF || seg !== SEG_OFF || dp !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid: an=%h seg=%b dp=%b fs=%b, required F 1111111 1 0", an, seg, dp, frame_start);
        end
        rst = 1'b0;
        pos = 1;
        lz_blank = 1'b1;
        exp_an  = '{4'hE, 4'hF, 4'hF, 4'hF};
        exp_seg = '{SEG_0, SEG_OFF, SEG_OFF, SEG_OFF};
        for (int k = 0; k < 4; k++) begin
            goto_pos(8 * k + 6);
            checks++;
            if (an !== exp_an[k] || seg !== exp_seg[k]) begin
                errors++;
                $display("[TB] FAIL rst_restart d%0d: an=%h seg=%b, required %h %b", k, an, seg, exp_an[k], exp_seg[k]);
            end
        end
        wait_frame(n);
        checks++;
        if (n != 2) begin errors++; $display("[TB] FAIL rst_frame: arrived after %0d cycles, required 2", n); end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_capture();
        test_lz_blank();
        test_digit_en();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
